// File: rtl/bus_ram_mar.sv
// Bus-attached RAM with integrated MAR, side-band programming port and sticky conflict flag.
// Define RAM_CLEAR_EN to zero every word after each reset before ready rises.
module bus_ram_mar #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              MI,
  input  logic              MINC,
  input  logic              RI,
  input  logic              RO,
  input  logic              prog_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_wr,
  output logic [ADDR_W-1:0] mar_out,
  output logic              ready,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PROG  = 2'd2
  } state_t;

`ifdef RAM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] mar_r;
  logic [ADDR_W-1:0] mar_nxt_s;
  logic              ready_r;
  logic              err_r;
  logic              err_nxt_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              clr_last_s;
  logic              run_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] rd_data_s;

`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_r;

  // Clear-sweep address; a reset mid-sweep restarts from word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr_r <= {ADDR_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      clr_addr_r <= clr_addr_r + ADDR_W'(1'b1);
    end else begin
      clr_addr_r <= {ADDR_W{1'b0}};
    end
  end

  assign clr_addr_s = clr_addr_r;
  assign clr_last_s = (clr_addr_r == {ADDR_W{1'b1}});
`else
  assign clr_addr_s = {ADDR_W{1'b0}};
  assign clr_last_s = 1'b0;
`endif

  // Commands are honoured only once ready is up, which implies RUN.
  assign run_s = (state_r == ST_RUN) && ready_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_last_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_CLEAR;
      end
      ST_RUN: begin
        if (prog_en) state_nxt_s = ST_PROG;
        else         state_nxt_s = ST_RUN;
      end
      ST_PROG: begin
        if (!prog_en) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_PROG;
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs: write-port mux, MAR next value and conflict flag.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = mar_r;
    mem_wdata_s = bus;
    mar_nxt_s   = mar_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_addr_s;
        mem_wdata_s = {DATA_W{1'b0}};
      end
      ST_RUN: begin
        if (run_s) begin
          // A simultaneous read and write is a bus conflict: keep the word, flag it.
          if (RI && RO) begin
            err_nxt_s = 1'b1;
          end else if (RI) begin
            mem_we_s = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
          if (MI) begin
            mar_nxt_s = bus[ADDR_W-1:0];
          end else if (MINC) begin
            mar_nxt_s = mar_r + ADDR_W'(1'b1);
          end else begin
            mar_nxt_s = mar_r;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_PROG: begin
        if (prog_wr) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = prog_addr;
          mem_wdata_s = prog_data;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Control registers: MAR, ready and the sticky conflict flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar_r   <= {ADDR_W{1'b0}};
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      mar_r   <= mar_nxt_s;
      ready_r <= (state_nxt_s == ST_RUN);
      err_r   <= err_nxt_s;
    end
  end

  // Storage array is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign rd_data_s = mem_r[mar_r];
  assign bus       = (RO && ready_r) ? rd_data_s : {DATA_W{1'bz}};
  assign mar_out   = mar_r;
  assign ready     = ready_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bus_ram_mar.sv
// Directed bench for bus_ram_mar (DATA_W=8, ADDR_W=4); covers both RAM_CLEAR_EN builds.
module tb_bus_ram_mar;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] bus;
  logic [7:0] bus_drv;
  logic       bus_oe;
  logic       MI, MINC, RI, RO;
  logic       prog_en, prog_wr;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] mar_out;
  logic       ready, err;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign bus = bus_oe ? bus_drv : 8'bzzzzzzzz;

  bus_ram_mar #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .MI(MI), .MINC(MINC), .RI(RI), .RO(RO),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_wr(prog_wr), .mar_out(mar_out), .ready(ready), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [7:0] a);
    bus_drv = a; bus_oe = 1'b1; MI = 1'b1;
    tick();
    MI = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic write_ram(input logic [7:0] d);
    bus_drv = d; bus_oe = 1'b1; RI = 1'b1;
    tick();
    RI = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    RO = 1'b1;
    #1;
    check(tag, bus, exp);
    RO = 1'b0;
  endtask

  // DUT must release the bus: we drive 0 while the addressed word is nonzero.
  task automatic released_chk(input string tag);
    bus_drv = 8'h00; bus_oe = 1'b1; RO = 1'b1;
    #1;
    check(tag, bus, 8'h00);
    RO = 1'b0; bus_oe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_drv = 8'h00; bus_oe = 1'b0;
    MI = 1'b0; MINC = 1'b0; RI = 1'b0; RO = 1'b0;
    prog_en = 1'b0; prog_wr = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    #2 rst = 1'b0;
    #2;
    check("rst_mar", {4'h0, mar_out}, 8'h00);
    check("rst_ready", {7'd0, ready}, 8'h00);
    check("rst_err", {7'd0, err}, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("ready_low_after_release", {7'd0, ready}, 8'h00);
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < 15; i++) tick();
    check("clear_ready_15", {7'd0, ready}, 8'h00);
    tick();
    check("clear_ready_16", {7'd0, ready}, 8'h01);
    for (int a = 0; a < 16; a++) begin
      load_mar(8'(a));
      read_chk($sformatf("clear_zero_%0d", a), 8'h00);
    end
`else
    tick();
    check("ready_first_edge", {7'd0, ready}, 8'h01);
`endif

    // MAR load, write, read-back.
    load_mar(8'h2A);
    check("mi_2a", {4'h0, mar_out}, 8'h0A);
    write_ram(8'h5C);
    read_chk("rd_5c", 8'h5C);

    // MAR wrap and MI-over-MINC priority.
    load_mar(8'h0F);
    check("mar_f", {4'h0, mar_out}, 8'h0F);
    MINC = 1'b1;
    tick();
    check("minc_wrap", {4'h0, mar_out}, 8'h00);
    tick();
    check("minc_step", {4'h0, mar_out}, 8'h01);
    bus_drv = 8'h03; bus_oe = 1'b1; MI = 1'b1;
    tick();
    MI = 1'b0; MINC = 1'b0; bus_oe = 1'b0;
    check("mi_prio", {4'h0, mar_out}, 8'h03);

    // RI with MI writes at the old MAR.
    load_mar(8'h05);
    bus_drv = 8'h0C; bus_oe = 1'b1; MI = 1'b1; RI = 1'b1;
    tick();
    MI = 1'b0; RI = 1'b0; bus_oe = 1'b0;
    check("ri_mi_mar", {4'h0, mar_out}, 8'h0C);
    load_mar(8'h05);
    read_chk("ri_mi_old_addr", 8'h0C);

    // Conflict: write suppressed, err sticky.
    load_mar(8'h02);
    write_ram(8'h11);
    read_chk("rd_11", 8'h11);
    check("err_before", {7'd0, err}, 8'h00);
    bus_drv = 8'h77; bus_oe = 1'b1; RO = 1'b1; RI = 1'b1;
    tick();
    RI = 1'b0; RO = 1'b0; bus_oe = 1'b0;
    check("err_set", {7'd0, err}, 8'h01);
    read_chk("conflict_kept", 8'h11);
    tick();
    tick();
    check("err_sticky", {7'd0, err}, 8'h01);

    // Programming mode: side-band write, bus commands ignored.
    prog_en = 1'b1;
    tick();
    check("prog_ready", {7'd0, ready}, 8'h00);
    prog_addr = 4'h7; prog_data = 8'hE0; prog_wr = 1'b1;
    bus_drv = 8'h55; bus_oe = 1'b1; MINC = 1'b1; RI = 1'b1;
    tick();
    prog_wr = 1'b0; MINC = 1'b0; RI = 1'b0; bus_oe = 1'b0;
    check("prog_mar_hold", {4'h0, mar_out}, 8'h02);
    released_chk("prog_bus_z");
    prog_en = 1'b0;
    tick();
    check("run_ready", {7'd0, ready}, 8'h01);
    load_mar(8'h07);
    read_chk("prog_rd_e0", 8'hE0);
    prog_addr = 4'h7; prog_data = 8'h99; prog_wr = 1'b1;
    tick();
    prog_wr = 1'b0;
    read_chk("prog_wr_ignored", 8'hE0);
    load_mar(8'h02);
    read_chk("prog_ri_ignored", 8'h11);

    // Reset clears err and MAR and releases the bus.
    load_mar(8'h00);
    write_ram(8'h3C);
    rst = 1'b0;
    #1;
    check("rst2_err", {7'd0, err}, 8'h00);
    check("rst2_ready", {7'd0, ready}, 8'h00);
    released_chk("rst2_bus_z");
    tick();
    rst = 1'b1;
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("restart_ready_15", {7'd0, ready}, 8'h00);
    tick();
    check("restart_ready_16", {7'd0, ready}, 8'h01);
    read_chk("restart_zero0", 8'h00);
    load_mar(8'h07);
    read_chk("restart_zero7", 8'h00);
`else
    tick();
    check("rst2_ready_up", {7'd0, ready}, 8'h01);
    read_chk("keep_3c", 8'h3C);
    load_mar(8'h07);
    read_chk("keep_e0", 8'hE0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
